usb_slave_fifo_tx: RTL

- Drains the 16-bit USB data FIFO and writes each word into the FX2 slave-FIFO IN endpoint.
- The FIFO is filled by the S-curve test control path; this block is the read side of that FIFO.
- Handles FX2 full back-pressure and commits short packets on a flush request or after an idle timeout.
- Sits between the USB data FIFO and the FX2 pins, in the same Clk domain.

---
 rtl/usb_tx_pkg.sv | 15 +
 rtl/usb_idle_timer.sv | 17 +
 rtl/usb_slave_fifo_tx.sv | 75 +++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared state encoding, FX2 endpoint addresses and default sizes for the slave-FIFO writer
package usb_tx_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_LAT    = 3'd2;
  localparam logic [2:0] S_WR     = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_PKTEND = 3'd5;
  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP4_ADDR = 2'b01;
  localparam logic [1:0] EP6_ADDR = 2'b10;
  localparam logic [1:0] EP8_ADDR = 2'b11;
  localparam int PKT_WORDS_DEF = 256;
  localparam int TIMEOUT_DEF = 4096;
endpackage

// File: rtl/usb_idle_timer.sv
// usb_idle_timer: saturating cycle counter with synchronous clear and count enable
module usb_idle_timer #(
  parameter int MAX = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam int W = $clog2(MAX + 1);
  logic [W-1:0] cnt;
  assign done = cnt == W'(MAX);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : (en && !done) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/usb_slave_fifo_tx.sv
// usb_slave_fifo_tx: drains the USB data FIFO into the FX2 slave-FIFO IN endpoint, committing short packets
module usb_slave_fifo_tx
  import usb_tx_pkg::*;
#(
  parameter int PKT_WORDS = PKT_WORDS_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter logic [1:0] EP_ADDR = EP6_ADDR
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic        tx_enable,
  input  logic        flush_req,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd_en,
  input  logic        usb_full_n,
  output logic [1:0]  usb_fifoadr,
  output logic        usb_slwr_n,
  output logic        usb_pktend_n,
  output logic [15:0] usb_fd,
  output logic        tx_busy,
  output logic [8:0]  pkt_word_cnt
);
  logic [2:0] state, state_nxt;
  logic flush_pend, timed_out, cnt_nz, go_rd, go_pkt, drop_flush, wr_fire;
  logic [8:0] cnt_inc;
  assign cnt_nz = pkt_word_cnt != '0;
  assign go_rd = state == S_IDLE && tx_enable && !fifo_empty;
  // commits only once the FIFO is empty so queued data always lands in the packet first
  assign go_pkt = state == S_IDLE && !go_rd && fifo_empty && (flush_pend || timed_out) && cnt_nz && usb_full_n;
  assign drop_flush = state == S_IDLE && !go_rd && fifo_empty && !cnt_nz;
  assign wr_fire = state == S_WR && usb_full_n;
  assign cnt_inc = pkt_word_cnt == 9'(PKT_WORDS - 1) ? '0 : pkt_word_cnt + 9'd1;
  usb_idle_timer #(.MAX(TIMEOUT_CYC)) u_timer (
    .clk (Clk),
    .rst (rst),
    .clr (wr_fire || state == S_PKTEND),
    .en  (state == S_IDLE && fifo_empty && cnt_nz),
    .done(timed_out)
  );
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = go_rd ? S_RD : go_pkt ? S_PKTEND : S_IDLE;
      S_RD:     state_nxt = S_LAT;
      S_LAT:    state_nxt = S_WR;
      S_WR:     state_nxt = usb_full_n ? S_GAP : S_WR;
      S_GAP:    state_nxt = S_IDLE;
      S_PKTEND: state_nxt = S_GAP;
      default:  state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge rst)
    if (rst) begin
      state        <= S_IDLE;
      tx_busy      <= 1'b0;
      fifo_rd_en   <= 1'b0;
      usb_slwr_n   <= 1'b1;
      usb_pktend_n <= 1'b1;
      usb_fd       <= '0;
      usb_fifoadr  <= EP_ADDR;
      pkt_word_cnt <= '0;
      flush_pend   <= 1'b0;
    end else begin
      state        <= state_nxt;
      tx_busy      <= state_nxt != S_IDLE;
      fifo_rd_en   <= go_rd;
      usb_slwr_n   <= !wr_fire;
      usb_pktend_n <= !go_pkt;
      usb_fd       <= state == S_LAT ? fifo_dout : usb_fd;
      usb_fifoadr  <= EP_ADDR;
      pkt_word_cnt <= state == S_PKTEND ? '0 : wr_fire ? cnt_inc : pkt_word_cnt;
      flush_pend   <= flush_req || (flush_pend && state != S_PKTEND && !drop_flush);
    end
endmodule
